gals_stream_producer: RTL and testbench
=======================================

Name: gals_stream_producer

Overview:
- Upstream stage for the GALS producer/consumer FIFO wrapper; runs entirely in the write-side clock domain (clock_1 of the FIFO).
- On a start pulse, emits a programmed number of 16-bit words on data_1/data_1_en, optionally spaced by idle gap cycles.
- Pattern is an incrementing counter or a 16-bit LFSR, so the downstream consumer can self-check.
- Honours the FIFO's buffer_full backpressure and reports progress: busy, done, sent count and XOR checksum of the emitted words.

Parameters:
- DATA_W, 16, data word width; fixed at 16 to match the FIFO.
- CNT_W, 8, width of word_count and sent_count.
- GAP_W, 4, width of the gap input.
- SEED, 16'h0001, initial pattern value after reset and at each start.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- mode  in  1  pattern select, latched at start: 0 = increment, 1 = LFSR.
- word_count  in  CNT_W  number of words to emit, latched at start.
- gap  in  GAP_W  idle cycles inserted after each word, latched at start.
- buffer_full  in  1  backpressure from the FIFO; no word is emitted while it is high.
- data_1  out  DATA_W  current pattern word.
- data_1_en  out  1  write strobe to the FIFO.
- busy  out  1  high in SEND and GAP.
- done  out  1  one-cycle pulse when a burst completes.
- sent_count  out  CNT_W  words emitted in the current or last burst.
- checksum  out  DATA_W  XOR of all words emitted in the current or last burst.

Behaviour:
- Reset is synchronous, active-high, one clock, one reset; nothing is asynchronous.
- Reset values: state=IDLE, data_1=SEED, data_1_en=0, busy=0, done=0, sent_count=0, checksum=0.
- Reset asserted mid-burst aborts the burst with no done pulse; data_1_en is low from the next cycle.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - on start=1, latch mode, word_count and gap into target, gap_r and mode_r.
  - load the pattern register with SEED; in LFSR mode a SEED of 0 is replaced by 16'h0001.
  - clear sent_count and checksum.
  - go to DONE if word_count==0, else go to SEND.
- SEND:
  - data_1_en = (state==SEND) && !buffer_full, combinational, so the FIFO samples the same-cycle full flag; data_1 = pattern register.
  - On an emit cycle: pattern advances, sent_count+1, checksum ^= data_1, all visible the next cycle.
  - After emitting, if sent_count+1 == target go to DONE; else if gap_r==0 stay in SEND (back-to-back words); else load gap counter = gap_r and go to GAP.
  - While buffer_full=1: no emit, data_1 holds its value, stay in SEND indefinitely.
- GAP: data_1_en=0; decrement the gap counter each cycle; go to SEND when the counter reaches 1, giving exactly gap_r idle cycles.
- DONE: done=1 for exactly one cycle, then return to IDLE. sent_count and checksum hold their values until the next start.
- start while busy or in DONE is ignored; it is not queued.
- Pattern update:
  - increment mode: p <= p+1, wrapping 16'hFFFF to 16'h0000.
  - LFSR mode: p <= {p[14:0], p[15]^p[13]^p[12]^p[10]}.
- Counters wrap modulo 2^CNT_W; word_count=255 emits 255 words.
- Word-to-word spacing with no backpressure is gap_r+1 cycles.

Decomposition:
- Shared package gals_pkg holds:
  - state encoding enum (IDLE, SEND, GAP, DONE).
  - LFSR tap constants and the PAT_INC/PAT_LFSR mode constants.
  - DATA_W=16, for reuse by the FIFO wrapper and the future consumer checker.
- One sub-module, gals_pattern_gen: holds the pattern register, with load, advance and mode inputs, and outputs the current word. The FSM, counters and checksum stay in the top module.

Test Plan:
- Increment burst: reset, then start with mode=0, word_count=4, gap=0, buffer_full=0 -> data_1_en high 4 consecutive cycles with data 0001, 0002, 0003, 0004. done pulses the following cycle; sent_count=4; checksum=16'h0004.
- Gap spacing: mode=0, word_count=3, gap=2 -> data_1_en pulses exactly 3 cycles apart with data 0001, 0002, 0003. busy is high from the cycle after start through the last GAP/SEND cycle.
- Backpressure: word_count=5, gap=0, buffer_full high for 5 cycles after the 2nd emit -> no strobes during that window; data_1 holds 0003; emission resumes the cycle buffer_full drops; total of 5 words, no word lost or duplicated.
- LFSR pattern: mode=1, word_count=3 -> words 0001, 0002, 0004; checksum=16'h0007.
- Zero count: word_count=0 -> data_1_en never asserted; done pulses 1 cycle after the start cycle; sent_count=0.
- Reset and restart: reset asserted after the 2nd word of an 8-word burst -> data_1_en low next cycle, all outputs at reset values, no done pulse. A start asserted during a later burst is ignored and sent_count ends at that burst's programmed count.

Source files
------------

// File: rtl/gals_pkg.sv
// gals_pkg: shared types and constants for the GALS producer/FIFO/consumer set.
// Holds the FSM state encoding, pattern mode codes, LFSR taps and the word width.
package gals_pkg;

  localparam int DATA_W = 16;

  // x^16 + x^14 + x^13 + x^11 + 1, as taps on bits 15, 13, 12, 10
  localparam logic [DATA_W-1:0] LFSR_TAPS = 16'hB400;

  localparam logic PAT_INC  = 1'b0;
  localparam logic PAT_LFSR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

  function automatic logic [DATA_W-1:0] lfsr_next(
    input logic [DATA_W-1:0] p
  );
    return {p[DATA_W-2:0], ^(p & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gals_stream_producer_if.sv
// gals_stream_producer_if: write-side link between producer and FIFO.
// master drives data_1/data_1_en and reads buffer_full; slave is the FIFO side.
interface gals_stream_producer_if;
  import gals_pkg::*;

  logic [DATA_W-1:0] data_1;
  logic              data_1_en;
  logic              buffer_full;

  modport master (
    output data_1,
    output data_1_en,
    input  buffer_full
  );

  modport slave (
    input  data_1,
    input  data_1_en,
    output buffer_full
  );

endinterface

// File: rtl/gals_pattern_gen.sv
// gals_pattern_gen: pattern register for the stream producer.
// Ports: clock, reset, load (reseed), advance (step), mode (0 inc, 1 LFSR), word.
module gals_pattern_gen
  import gals_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED = 16'h0001
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic              mode,
  output logic [DATA_W-1:0] word
);

  // An all-zero LFSR would lock up, so LFSR mode never seeds with zero.
  localparam logic [DATA_W-1:0] LFSR_SEED =
    (SEED == '0) ? 16'h0001 : SEED;

  logic [DATA_W-1:0] seed_val;
  logic [DATA_W-1:0] step_val;

  always_comb begin
    seed_val = SEED;
    step_val = word + 1'b1;
    if (mode == PAT_LFSR) begin
      seed_val = LFSR_SEED;
      step_val = lfsr_next(word);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word <= SEED;
    end else if (load) begin
      word <= seed_val;
    end else if (advance) begin
      word <= step_val;
    end
  end

endmodule

// File: rtl/gals_stream_producer.sv
// gals_stream_producer: burst word source for the write side of the GALS FIFO.
// Ports: clock, reset, start/mode/word_count/gap (burst setup), fifo (data_1,
//   data_1_en out, buffer_full in), busy, done, sent_count, checksum.
module gals_stream_producer
  import gals_pkg::*;
#(
  parameter int                CNT_W = 8,
  parameter int                GAP_W = 4,
  parameter logic [DATA_W-1:0] SEED  = 16'h0001
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          mode,
  input  logic [CNT_W-1:0]              word_count,
  input  logic [GAP_W-1:0]              gap,
  gals_stream_producer_if.master        fifo,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              sent_count,
  output logic [DATA_W-1:0]             checksum
);

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]  target;
  logic [GAP_W-1:0]  gap_r;
  logic              mode_r;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CNT_W-1:0]  sent_inc;
  logic [DATA_W-1:0] pat;
  logic              emit;
  logic              load;
  logic              to_gap;
  logic              pat_mode;

  // Combinational so the FIFO sees a strobe gated by its same-cycle full flag.
  assign emit     = (state == SEND) && !fifo.buffer_full;
  assign sent_inc = sent_count + 1'b1;

  // The reseed happens in the start cycle, before mode_r holds the new mode.
  assign pat_mode = (state == IDLE) ? mode : mode_r;

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    to_gap   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = (word_count == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (emit) begin
          if (sent_inc == target) begin
            state_nx = DONE;
          end else if (gap_r != '0) begin
            state_nx = GAP;
            to_gap   = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_nx = SEND;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      target     <= '0;
      gap_r      <= '0;
      mode_r     <= PAT_INC;
      gap_cnt    <= '0;
      sent_count <= '0;
      checksum   <= '0;
    end else begin
      if (load) begin
        target     <= word_count;
        gap_r      <= gap;
        mode_r     <= mode;
        sent_count <= '0;
        checksum   <= '0;
      end
      if (emit) begin
        sent_count <= sent_inc;
        checksum   <= checksum ^ pat;
      end
      if (to_gap) begin
        gap_cnt <= gap_r;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  gals_pattern_gen #(
    .SEED (SEED)
  ) u_pat (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .advance (emit),
    .mode    (pat_mode),
    .word    (pat)
  );

  assign fifo.data_1    = pat;
  assign fifo.data_1_en = emit;
  assign busy           = (state == SEND) || (state == GAP);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_gals_stream_producer.sv
// tb_gals_stream_producer: directed bench for gals_stream_producer.
// Scenario tasks run in sequence; a negedge monitor logs strobes and pulses.
module tb_gals_stream_producer;
  import gals_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        mode;
  logic [7:0]  word_count;
  logic [3:0]  gap;
  logic        busy;
  logic        done;
  logic [7:0]  sent_count;
  logic [15:0] checksum;

  gals_stream_producer_if fifo_if();

  gals_stream_producer #(
    .CNT_W (8),
    .GAP_W (4),
    .SEED  (16'h0001)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .word_count (word_count),
    .gap        (gap),
    .fifo       (fifo_if),
    .busy       (busy),
    .done       (done),
    .sent_count (sent_count),
    .checksum   (checksum)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] wq[$];
  int          cq[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          busy_cnt = 0;

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (fifo_if.data_1_en === 1'b1) begin
      wq.push_back(fifo_if.data_1);
      cq.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  task automatic nc();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  task automatic start_burst(
    input  logic       m,
    input  logic [7:0] wc,
    input  logic [3:0] g,
    output int         s_cyc,
    output int         wb,
    output int         db,
    output int         bb
  );
    nc();
    start      = 1'b1;
    mode       = m;
    word_count = wc;
    gap        = g;
    s_cyc      = cyc;
    wb         = wq.size();
    db         = done_cnt;
    bb         = busy_cnt;
    nc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int db, input int limit);
    int n = 0;
    while (done_cnt == db && n < limit) begin
      sample();
      n++;
    end
    checks++;
    if (done_cnt == db) begin
      errors++;
      $display("FAIL wait_done: no done pulse in %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    word_count = '0;
    gap = '0;
    fifo_if.buffer_full = 1'b0;
    repeat (2) nc();
    sample();
    checks++;
    if (fifo_if.data_1_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_en: got %b want 0", fifo_if.data_1_en);
    end
    checks++;
    if (fifo_if.data_1 !== 16'h0001) begin
      errors++;
      $display("FAIL reset_data: got %h want 0001", fifo_if.data_1);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_done: got %b%b want 00", busy, done);
    end
    checks++;
    if (sent_count !== 8'd0 || checksum !== 16'h0000) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%h want 0/0000",
               sent_count, checksum);
    end
    nc();
    reset = 1'b0;
  endtask

  task automatic test_increment();
    int s, wb, db, bb;
    start_burst(1'b0, 8'd4, 4'd0, s, wb, db, bb);
    wait_done(db, 20);
    checks++;
    if (wq.size() - wb != 4) begin
      errors++;
      $display("FAIL inc_count: got %0d words want 4", wq.size() - wb);
    end
    for (int i = 0; i < 4; i++) begin
      if (wb + i < wq.size()) begin
        checks++;
        if (wq[wb+i] !== 16'(i + 1) || cq[wb+i] != s + 1 + i) begin
          errors++;
          $display("FAIL inc_word%0d: got %h@%0d want %h@%0d",
                   i, wq[wb+i], cq[wb+i], i + 1, s + 1 + i);
        end
      end
    end
    checks++;
    if (done_cyc != s + 5) begin
      errors++;
      $display("FAIL inc_done_cyc: got %0d want %0d", done_cyc, s + 5);
    end
    checks++;
    if (sent_count !== 8'd4 || checksum !== 16'h0004) begin
      errors++;
      $display("FAIL inc_sum: got %0d/%h want 4/0004", sent_count, checksum);
    end
    sample();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt != db + 1) begin
      errors++;
      $display("FAIL inc_after: done %b busy %b pulses %0d want 0 0 1",
               done, busy, done_cnt - db);
    end
  endtask

  task automatic test_gap();
    int s, wb, db, bb;
    start_burst(1'b0, 8'd3, 4'd2, s, wb, db, bb);
    wait_done(db, 40);
    checks++;
    if (wq.size() - wb != 3) begin
      errors++;
      $display("FAIL gap_count: got %0d words want 3", wq.size() - wb);
    end else begin
      checks++;
      if (wq[wb] !== 16'h0001 || wq[wb+1] !== 16'h0002 ||
          wq[wb+2] !== 16'h0003) begin
        errors++;
        $display("FAIL gap_data: got %h %h %h want 0001 0002 0003",
                 wq[wb], wq[wb+1], wq[wb+2]);
      end
      checks++;
      if (cq[wb] != s + 1 || cq[wb+1] - cq[wb] != 3 ||
          cq[wb+2] - cq[wb+1] != 3) begin
        errors++;
        $display("FAIL gap_spacing: got %0d %0d %0d want %0d +3 +3",
                 cq[wb], cq[wb+1], cq[wb+2], s + 1);
      end
      checks++;
      if (done_cyc != cq[wb+2] + 1) begin
        errors++;
        $display("FAIL gap_done_cyc: got %0d want %0d",
                 done_cyc, cq[wb+2] + 1);
      end
    end
    checks++;
    if (busy_cnt - bb != 7) begin
      errors++;
      $display("FAIL gap_busy: got %0d busy cycles want 7", busy_cnt - bb);
    end
  endtask

  task automatic test_backpressure();
    int s, wb, db, bb;
    int n = 0;
    start_burst(1'b0, 8'd5, 4'd0, s, wb, db, bb);
    while (wq.size() - wb < 2 && n < 20) begin
      sample();
      n++;
    end
    checks++;
    if (wq.size() - wb < 2) begin
      errors++;
      $display("FAIL bp_first: got %0d words want 2", wq.size() - wb);
    end
    nc();
    fifo_if.buffer_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) nc();
      sample();
      checks++;
      if (fifo_if.data_1_en !== 1'b0 || fifo_if.data_1 !== 16'h0003 ||
          busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: en %b data %h busy %b want 0 0003 1",
                 k, fifo_if.data_1_en, fifo_if.data_1, busy);
      end
    end
    nc();
    fifo_if.buffer_full = 1'b0;
    sample();
    checks++;
    if (fifo_if.data_1_en !== 1'b1 || fifo_if.data_1 !== 16'h0003) begin
      errors++;
      $display("FAIL bp_resume: en %b data %h want 1 0003",
               fifo_if.data_1_en, fifo_if.data_1);
    end
    wait_done(db, 20);
    checks++;
    if (wq.size() - wb != 5) begin
      errors++;
      $display("FAIL bp_count: got %0d words want 5", wq.size() - wb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wq[wb+i] !== 16'(i + 1)) begin
          errors++;
          $display("FAIL bp_word%0d: got %h want %h", i, wq[wb+i], i + 1);
        end
      end
      checks++;
      if (cq[wb+2] - cq[wb+1] != 6) begin
        errors++;
        $display("FAIL bp_stall: got gap %0d want 6", cq[wb+2] - cq[wb+1]);
      end
    end
    checks++;
    if (sent_count !== 8'd5 || checksum !== 16'h0001) begin
      errors++;
      $display("FAIL bp_sum: got %0d/%h want 5/0001", sent_count, checksum);
    end
  endtask

  task automatic test_lfsr();
    int s, wb, db, bb;
    start_burst(1'b1, 8'd3, 4'd0, s, wb, db, bb);
    wait_done(db, 20);
    checks++;
    if (wq.size() - wb != 3) begin
      errors++;
      $display("FAIL lfsr_count: got %0d words want 3", wq.size() - wb);
    end else begin
      checks++;
      if (wq[wb] !== 16'h0001 || wq[wb+1] !== 16'h0002 ||
          wq[wb+2] !== 16'h0004) begin
        errors++;
        $display("FAIL lfsr_data: got %h %h %h want 0001 0002 0004",
                 wq[wb], wq[wb+1], wq[wb+2]);
      end
    end
    checks++;
    if (sent_count !== 8'd3 || checksum !== 16'h0007) begin
      errors++;
      $display("FAIL lfsr_sum: got %0d/%h want 3/0007", sent_count, checksum);
    end
  endtask

  task automatic test_zero();
    int s, wb, db, bb;
    start_burst(1'b0, 8'd0, 4'd3, s, wb, db, bb);
    wait_done(db, 10);
    checks++;
    if (done_cyc != s + 1) begin
      errors++;
      $display("FAIL zero_done_cyc: got %0d want %0d", done_cyc, s + 1);
    end
    checks++;
    if (wq.size() != wb || busy_cnt != bb) begin
      errors++;
      $display("FAIL zero_quiet: got %0d words %0d busy want 0 0",
               wq.size() - wb, busy_cnt - bb);
    end
    checks++;
    if (sent_count !== 8'd0 || checksum !== 16'h0000) begin
      errors++;
      $display("FAIL zero_sum: got %0d/%h want 0/0000", sent_count, checksum);
    end
  endtask

  task automatic test_max_count();
    int s, wb, db, bb;
    start_burst(1'b0, 8'd255, 4'd0, s, wb, db, bb);
    wait_done(db, 400);
    checks++;
    if (wq.size() - wb != 255) begin
      errors++;
      $display("FAIL max_count: got %0d words want 255", wq.size() - wb);
    end else begin
      checks++;
      if (wq[wb+254] !== 16'h00FF || done_cyc != s + 256) begin
        errors++;
        $display("FAIL max_last: got %h done@%0d want 00ff done@%0d",
                 wq[wb+254], done_cyc, s + 256);
      end
    end
    checks++;
    if (sent_count !== 8'd255 || checksum !== 16'h0000) begin
      errors++;
      $display("FAIL max_sum: got %0d/%h want 255/0000", sent_count, checksum);
    end
  endtask

  task automatic test_reset_abort();
    int s, wb, db, bb;
    int n = 0;
    start_burst(1'b0, 8'd8, 4'd0, s, wb, db, bb);
    while (wq.size() - wb < 2 && n < 20) begin
      sample();
      n++;
    end
    nc();
    reset = 1'b1;
    nc();
    sample();
    checks++;
    if (fifo_if.data_1_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_ctl: en %b busy %b done %b want 000",
               fifo_if.data_1_en, busy, done);
    end
    checks++;
    if (fifo_if.data_1 !== 16'h0001 || sent_count !== 8'd0 ||
        checksum !== 16'h0000) begin
      errors++;
      $display("FAIL abort_vals: got %h %0d %h want 0001 0 0000",
               fifo_if.data_1, sent_count, checksum);
    end
    nc();
    reset = 1'b0;
    repeat (6) sample();
    checks++;
    if (done_cnt != db) begin
      errors++;
      $display("FAIL abort_done: got %0d pulses want 0", done_cnt - db);
    end
  endtask

  task automatic test_ignored_start();
    int s, wb, db, bb;
    int n = 0;
    int wb2, bb2;
    start_burst(1'b0, 8'd3, 4'd2, s, wb, db, bb);
    while (wq.size() == wb && n < 20) begin
      sample();
      n++;
    end
    nc();
    start      = 1'b1;
    mode       = 1'b1;
    word_count = 8'd9;
    nc();
    start = 1'b0;
    wait_done(db, 40);
    checks++;
    if (sent_count !== 8'd3 || wq.size() - wb != 3) begin
      errors++;
      $display("FAIL ign_count: got %0d sent %0d words want 3 3",
               sent_count, wq.size() - wb);
    end else begin
      checks++;
      if (wq[wb+2] !== 16'h0003) begin
        errors++;
        $display("FAIL ign_data: got %h want 0003", wq[wb+2]);
      end
    end
    sample();
    wb2 = wq.size();
    bb2 = busy_cnt;
    repeat (12) sample();
    checks++;
    if (wq.size() != wb2 || busy_cnt != bb2) begin
      errors++;
      $display("FAIL ign_restart: got %0d words %0d busy want 0 0",
               wq.size() - wb2, busy_cnt - bb2);
    end
  endtask

  initial begin
    test_reset();
    test_increment();
    test_gap();
    test_backpressure();
    test_lfsr();
    test_zero();
    test_max_count();
    test_reset_abort();
    test_ignored_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
